uart_tx_buffered: RTL and testbench

- Byte-wide serial transmitter fed by a small synchronous FIFO. It drains captured bytes (SPI trace/debug data) to the host UART as 8N1 frames.
- Sits downstream of the producer logic. Consumes the single-cycle baud tick from a divide_by_n instance (N = clk_hz / baud) and drives the TX pin.
- Buffering decouples bursty byte producers from the slow serial line.

---
 rtl/uart_tx_buffered_pkg.sv | 21 ++
 rtl/uart_tx_buffered_sync_fifo.sv | 72 +++++++
 rtl/uart_tx_buffered.sv | 121 ++++++++++++
 tb/tb_uart_tx_buffered.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding
// and 8N1 frame geometry.
package uart_tx_buffered_pkg;

    // Transmitter state encoding; values are fixed so the state reads the
    // same in waveforms and in any software that decodes it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // One start bit, eight data bits and one stop bit.
    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = UART_FRAME_BITS - 2;

    // Bit counter value that marks the last data bit of a frame.
    localparam logic [2:0] UART_LAST_BIT = 3'(UART_DATA_BITS - 1);

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Byte-wide synchronous FIFO with a first-word-fall-through head.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [7:0]    wdata,
    input  logic          rd,
    output logic [7:0]    rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;
    assign count = count_q;

    // The head is visible without a read cycle so the transmitter can load
    // it on the same baud tick that pops it.
    assign rdata = mem_q[rd_ptr_q];

    // Occupancy only moves when exactly one of push/pop takes effect.
    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH = 2**AW.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes are queued in a small FIFO and sent
// LSB first, one line level per baud_tick, with back-to-back frames when
// more data is waiting.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          baud_tick,
    input  logic [7:0]    data,
    input  logic          data_strobe,
    output logic          ready,
    output logic          overflow,
    input  logic          overflow_clr,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          serial
);

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic        serial_q;
    logic        overflow_q;

    logic [7:0]  fifo_rdata;
    logic [AW:0] fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (data_strobe),
        .wdata (data),
        .rd    (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A byte leaves the FIFO only when a new frame starts: from IDLE, or
    // straight out of STOP so consecutive frames have no idle gap.
    assign pop = baud_tick && !fifo_empty && ((state_q == IDLE) || (state_q == STOP));

    assign ready    = !fifo_full;
    assign count    = fifo_count;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign serial   = serial_q;
    assign overflow = overflow_q;

    // Sticky overflow: a dropped byte wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (data_strobe && fifo_full) begin
            overflow_q <= 1'b1;
        end else if (overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end

    // Transmit FSM; every transition waits for a baud tick so each line
    // level lasts exactly one bit period.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            serial_q  <= 1'b1;
        end else if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q  <= fifo_rdata;
                        serial_q <= 1'b0;
                        state_q  <= START;
                    end
                end
                START: begin
                    serial_q  <= shift_q[0];
                    bit_cnt_q <= '0;
                    state_q   <= DATA;
                end
                DATA: begin
                    if (bit_cnt_q != UART_LAST_BIT) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        serial_q  <= shift_q[1];
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end else begin
                        serial_q <= 1'b1;
                        state_q  <= STOP;
                    end
                end
                STOP: begin
                    if (pop) begin
                        shift_q  <= fifo_rdata;
                        serial_q <= 1'b0;
                        state_q  <= START;
                    end else begin
                        serial_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    serial_q <= 1'b1;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: bytes pushed into a scoreboard on
// accepted writes are matched against frames decoded from the serial line.
module tb_uart_tx_buffered;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          baud_tick = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          data_strobe = 1'b0;
    logic          overflow_clr = 1'b0;
    logic          ready;
    logic          overflow;
    logic [AW:0]   count;
    logic          busy;
    logic          serial;

    int            vectors = 0;
    int            miscompares = 0;
    int            tick_phase = 0;
    logic [7:0]    sb [$];

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .baud_tick    (baud_tick),
        .data         (data),
        .data_strobe  (data_strobe),
        .ready        (ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .count        (count),
        .busy         (busy),
        .serial       (serial)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One clock of a free-running divide-by-4 baud tick.
    task automatic ptick();
        baud_tick = (tick_phase == 3);
        tick_phase = (tick_phase + 1) % 4;
        cyc();
        baud_tick = 1'b0;
    endtask

    // A single isolated tick followed by two quiet clocks.
    task automatic mtick();
        baud_tick = 1'b1;
        cyc();
        baud_tick = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic write_byte(input logic [7:0] b, input bit accept);
        data = b;
        data_strobe = 1'b1;
        if (accept) sb.push_back(b);
        cyc();
        data_strobe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        cyc();
        reset = 1'b0;
    endtask

    // Serial monitor: samples the line right after every baud tick edge and
    // rebuilds 8N1 frames, comparing each byte with the scoreboard head.
    initial begin
        int         mon_phase;
        int         mon_bits;
        logic [7:0] mon_byte;
        logic [7:0] exp_byte;
        mon_phase = 0;
        mon_bits  = 0;
        mon_byte  = 8'h00;
        forever begin
            @(posedge clk);
            if (reset) begin
                mon_phase = 0;
                mon_bits  = 0;
            end else if (baud_tick) begin
                #1;
                case (mon_phase)
                    0: if (serial == 1'b0) begin
                        mon_phase = 1;
                        mon_bits  = 0;
                    end
                    1: begin
                        mon_byte = {serial, mon_byte[7:1]};
                        mon_bits++;
                        if (mon_bits == 8) mon_phase = 2;
                    end
                    default: begin
                        check("stop_bit", {31'd0, serial}, 32'd1);
                        if (sb.size() == 0) begin
                            check("frame_without_write", {24'd0, mon_byte}, 32'hFFFF_FFFF);
                        end else begin
                            exp_byte = sb.pop_front();
                            check("frame_byte", {24'd0, mon_byte}, {24'd0, exp_byte});
                            $display("frame decoded: %02h (expected %02h)", mon_byte, exp_byte);
                        end
                        mon_phase = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] pat;

        // ---- reset state ----
        cyc();
        do_reset();
        check("rst_serial",   {31'd0, serial},   32'd1);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_count",    {27'd0, count},    32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_ready",    {31'd0, ready},    32'd1);

        // ---- single byte 0x55, tick every 4 clk ----
        write_byte(8'h55, 1'b1);
        check("t1_count", {27'd0, count}, 32'd1);
        check("t1_busy",  {31'd0, busy},  32'd1);
        tick_phase = 0;
        for (int i = 0; i < 3; i++) begin
            ptick();
            check("t1_wait_idle", {31'd0, serial}, 32'd1);
        end
        ptick();
        pat = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 40; k++) begin
            check("t1_line", {31'd0, serial}, {31'd0, pat[k / 4]});
            if (k == 39) check("t1_busy_stop", {31'd0, busy}, 32'd1);
            ptick();
        end
        check("t1_idle_serial", {31'd0, serial}, 32'd1);
        check("t1_idle_busy",   {31'd0, busy},   32'd0);

        // ---- back-to-back frames 0xA5, 0x3C ----
        write_byte(8'hA5, 1'b1);
        write_byte(8'h3C, 1'b1);
        check("t2_count2", {27'd0, count}, 32'd2);
        tick_phase = 0;
        for (int i = 0; i < 4; i++) ptick();
        check("t2_start1", {31'd0, serial}, 32'd0);
        check("t2_count1", {27'd0, count},  32'd1);
        for (int i = 0; i < 36; i++) ptick();
        check("t2_stop1",  {31'd0, serial}, 32'd1);
        check("t2_count1b", {27'd0, count}, 32'd1);
        for (int i = 0; i < 4; i++) ptick();
        check("t2_start2_no_gap", {31'd0, serial}, 32'd0);
        check("t2_count0", {27'd0, count}, 32'd0);
        for (int i = 0; i < 40; i++) ptick();
        check("t2_idle_busy",   {31'd0, busy},   32'd0);
        check("t2_idle_serial", {31'd0, serial}, 32'd1);

        // ---- fill to DEPTH with no ticks, then overflow ----
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            check("t3_ready_before", {31'd0, ready}, 32'd1);
            write_byte(8'(8'h40 + i), 1'b1);
            check("t3_count", {27'd0, count}, 32'(i + 1));
        end
        check("t3_ready_full", {31'd0, ready},    32'd0);
        check("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
        write_byte(8'hEE, 1'b0);
        check("t3_ovf_set",    {31'd0, overflow}, 32'd1);
        check("t3_count_held", {27'd0, count},    32'd16);
        overflow_clr = 1'b1;
        write_byte(8'hEF, 1'b0);
        check("t3_set_beats_clr", {31'd0, overflow}, 32'd1);
        cyc();
        overflow_clr = 1'b0;
        check("t3_ovf_cleared", {31'd0, overflow}, 32'd0);
        check("t3_count_16",    {27'd0, count},    32'd16);

        // ---- full FIFO: write and pop on the same cycle ----
        do_reset();
        write_byte(8'h11, 1'b1);
        mtick();
        check("t4_started", {31'd0, serial}, 32'd0);
        check("t4_count0",  {27'd0, count},  32'd0);
        for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h80 + i), 1'b1);
        check("t4_full", {27'd0, count}, 32'd16);
        for (int i = 0; i < 9; i++) mtick();
        check("t4_in_stop", {31'd0, serial}, 32'd1);
        data = 8'hEE;
        data_strobe = 1'b1;
        baud_tick = 1'b1;
        cyc();
        data_strobe = 1'b0;
        baud_tick = 1'b0;
        check("t4_ovf",      {31'd0, overflow}, 32'd1);
        check("t4_count15",  {27'd0, count},    32'd15);
        check("t4_next_start", {31'd0, serial}, 32'd0);

        // ---- reset in the middle of a frame ----
        do_reset();
        write_byte(8'hFF, 1'b1);
        write_byte(8'h01, 1'b1);
        write_byte(8'h02, 1'b1);
        write_byte(8'h03, 1'b1);
        check("t5_count4", {27'd0, count}, 32'd4);
        for (int i = 0; i < 5; i++) mtick();
        check("t5_count3", {27'd0, count}, 32'd3);
        do_reset();
        check("t5_serial", {31'd0, serial}, 32'd1);
        check("t5_count",  {27'd0, count},  32'd0);
        check("t5_busy",   {31'd0, busy},   32'd0);
        tick_phase = 0;
        for (int i = 0; i < 48; i++) begin
            ptick();
            check("t5_quiet", {31'd0, serial}, 32'd1);
        end

        // ---- queued byte waits for the first tick ----
        write_byte(8'h96, 1'b1);
        for (int i = 0; i < 100; i++) begin
            cyc();
            check("t6_hold_serial", {31'd0, serial}, 32'd1);
        end
        check("t6_count1", {27'd0, count}, 32'd1);
        check("t6_busy",   {31'd0, busy},  32'd1);
        mtick();
        check("t6_start",  {31'd0, serial}, 32'd0);
        check("t6_count0", {27'd0, count},  32'd0);
        for (int i = 0; i < 10; i++) mtick();
        check("t6_done_busy", {31'd0, busy}, 32'd0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
